// File: rtl/drum_pkg.sv
// drum_pkg: shared meter encodings, transport FSM states and the
// step threshold helper for the drum step scheduler.
package drum_pkg;

    localparam logic [1:0] METER_16 = 2'b00;
    localparam logic [1:0] METER_8  = 2'b01;
    localparam logic [1:0] METER_4  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One sixteenth note at 1 BPM, in system clocks.
    function automatic longint step_thresh(input longint clk_hz);
        return clk_hz * 64'sd15;
    endfunction

endpackage

// File: rtl/drum_tempo_nco.sv
// drum_tempo_nco: phase accumulator that turns a BPM value into a
// single-cycle step enable.
module drum_tempo_nco
    import drum_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int ACC_W  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] bpm,
    output logic       tick,
    output logic       ccen
);

    localparam logic [ACC_W-1:0] THRESH =
        ACC_W'(step_thresh(longint'(CLK_HZ)));

    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic             ccen_q;

    // Accumulate and wrap; tick marks the edge that raises CCEN.
    always_comb begin
        sum   = acc_q + ACC_W'(bpm);
        tick  = (sum >= THRESH);
        acc_d = tick ? (sum - THRESH) : sum;
    end

    // Accumulator and registered step enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            ccen_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            ccen_q <= tick;
        end
    end

    assign ccen = ccen_q;

endmodule

// File: rtl/drum_step_scheduler.sv
// drum_step_scheduler: transport FSM, tempo, meter latch, step and
// trigger-window counters around the tempo NCO.
module drum_step_scheduler
    import drum_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int ACC_W       = 32,
    parameter int BPM_MIN     = 60,
    parameter int BPM_MAX     = 240,
    parameter int BPM_STEP    = 4,
    parameter int BPM_INIT    = 120,
    parameter int TRIG_CYCLES = 1_000_000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Stop,
    input  logic       TempoUp,
    input  logic       TempoDown,
    input  logic [1:0] MeterSel,
    output logic       CCEN,
    output logic       SeqStart,
    output logic       SeqStop,
    output logic       Fourths,
    output logic       Eighths,
    output logic       Running,
    output logic [3:0] StepIdx,
    output logic [7:0] Bpm,
    output logic       Beat,
    output logic       TrigWin
);

    localparam int               CNT_W   = $clog2(TRIG_CYCLES + 1);
    localparam logic [CNT_W-1:0] TRIG_LD = CNT_W'(TRIG_CYCLES);
    localparam logic [8:0]       MIN9    = 9'(BPM_MIN);
    localparam logic [8:0]       MAX9    = 9'(BPM_MAX);
    localparam logic [8:0]       STEP9   = 9'(BPM_STEP);
    localparam logic [7:0]       INIT8   = 8'(BPM_INIT);

    state_t           state_q, state_d;
    logic             spend_q, spend_d;
    logic             ppend_q, ppend_d;
    logic [3:0]       step_q, step_d, step_nx, step_mask;
    logic             fourths_q, fourths_d;
    logic             eighths_q, eighths_d;
    logic             sstart_q, sstart_d;
    logic             sstop_q, sstop_d;
    logic             beat_q, beat_d;
    logic [7:0]       bpm_q, bpm_d;
    logic [8:0]       bpm_up, bpm_dn;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trig_q, trig_d;
    logic             tick;

    drum_tempo_nco #(
        .CLK_HZ (CLK_HZ),
        .ACC_W  (ACC_W)
    ) u_nco (
        .clk   (Clk),
        .reset (Reset),
        .bpm   (bpm_q),
        .tick  (tick),
        .ccen  (CCEN)
    );

    // Tempo stepping with saturation at both ends.
    always_comb begin
        bpm_d  = bpm_q;
        bpm_up = {1'b0, bpm_q} + STEP9;
        bpm_dn = {1'b0, bpm_q} - STEP9;
        if (TempoUp && !TempoDown) begin
            bpm_d = (bpm_up > MAX9) ? MAX9[7:0] : bpm_up[7:0];
        end else if (TempoDown && !TempoUp) begin
            bpm_d = ({1'b0, bpm_q} < (MIN9 + STEP9)) ? MIN9[7:0] : bpm_dn[7:0];
        end
    end

    // Transport FSM, meter latch, step counter and trigger window.
    always_comb begin
        state_d   = state_q;
        spend_d   = spend_q;
        ppend_d   = ppend_q;
        step_d    = step_q;
        fourths_d = fourths_q;
        eighths_d = eighths_q;
        sstart_d  = 1'b0;
        sstop_d   = 1'b0;
        beat_d    = 1'b0;
        step_mask = fourths_q ? 4'd3 : (eighths_q ? 4'd7 : 4'd15);
        step_nx   = (step_q + 4'd1) & step_mask;

        unique case (state_q)
            ST_IDLE: begin
                fourths_d = (MeterSel == METER_4);
                eighths_d = (MeterSel == METER_8);
                if (tick && spend_q) begin
                    state_d  = ST_RUN;
                    spend_d  = 1'b0;
                    sstart_d = 1'b1;
                    step_d   = 4'd0;
                end else if (Start && !Stop) begin
                    spend_d = 1'b1;
                end else if (Stop && !Start) begin
                    spend_d = 1'b0;
                end
            end
            ST_RUN: begin
                // The sequencer ignores Stop in step 0, so defer it a step.
                if (tick && ppend_q && (step_q != 4'd0)) begin
                    state_d = ST_IDLE;
                    ppend_d = 1'b0;
                    sstop_d = 1'b1;
                    step_d  = 4'd0;
                end else begin
                    if (tick) begin
                        step_d = step_nx;
                        if (step_nx == 4'd0) begin
                            beat_d    = 1'b1;
                            fourths_d = (MeterSel == METER_4);
                            eighths_d = (MeterSel == METER_8);
                        end
                    end
                    if (Stop) begin
                        ppend_d = 1'b1;
                    end
                end
            end
        endcase

        cnt_d = cnt_q;
        if ((state_d == ST_RUN) && tick) begin
            cnt_d = TRIG_LD;
        end else if (state_d == ST_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
        trig_d = (cnt_d != '0);
    end

    // State registers; reset aborts any run immediately.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            spend_q   <= 1'b0;
            ppend_q   <= 1'b0;
            step_q    <= 4'd0;
            fourths_q <= 1'b0;
            eighths_q <= 1'b0;
            sstart_q  <= 1'b0;
            sstop_q   <= 1'b0;
            beat_q    <= 1'b0;
            bpm_q     <= INIT8;
            cnt_q     <= '0;
            trig_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            spend_q   <= spend_d;
            ppend_q   <= ppend_d;
            step_q    <= step_d;
            fourths_q <= fourths_d;
            eighths_q <= eighths_d;
            sstart_q  <= sstart_d;
            sstop_q   <= sstop_d;
            beat_q    <= beat_d;
            bpm_q     <= bpm_d;
            cnt_q     <= cnt_d;
            trig_q    <= trig_d;
        end
    end

    assign SeqStart = sstart_q;
    assign SeqStop  = sstop_q;
    assign Fourths  = fourths_q;
    assign Eighths  = eighths_q;
    assign Running  = (state_q == ST_RUN);
    assign StepIdx  = step_q;
    assign Bpm      = bpm_q;
    assign Beat     = beat_q;
    assign TrigWin  = trig_q;

endmodule

// File: tb/tb_drum_step_scheduler.sv
// tb_drum_step_scheduler: directed transport scenarios plus random
// stimulus, every cycle checked against a behavioural model.
module tb_drum_step_scheduler;

    localparam int THRESH = 800 * 15;
    localparam int TRIG   = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       up = 1'b0;
    logic       dn = 1'b0;
    logic [1:0] ms = 2'b00;
    logic       ccen, seq_start, seq_stop, fourths, eighths;
    logic       running, beat, trig_win;
    logic [3:0] step_idx;
    logic [7:0] bpm;

    always #5 clk = ~clk;

    drum_step_scheduler #(
        .CLK_HZ      (800),
        .TRIG_CYCLES (TRIG)
    ) dut (
        .Clk       (clk),
        .Reset     (rst),
        .Start     (start),
        .Stop      (stop),
        .TempoUp   (up),
        .TempoDown (dn),
        .MeterSel  (ms),
        .CCEN      (ccen),
        .SeqStart  (seq_start),
        .SeqStop   (seq_stop),
        .Fourths   (fourths),
        .Eighths   (eighths),
        .Running   (running),
        .StepIdx   (step_idx),
        .Bpm       (bpm),
        .Beat      (beat),
        .TrigWin   (trig_win)
    );

    int total = 0;
    int bad   = 0;

    int         m_acc, m_bpm, m_step, m_len, m_cnt;
    bit         m_play, m_spend, m_ppend;
    bit         e_ccen, e_start, e_stop, e_beat;
    logic [1:0] cur_ms = 2'b00;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int len_of(input logic [1:0] sel);
        return (sel == 2'b01) ? 8 : ((sel == 2'b10) ? 4 : 16);
    endfunction

    task automatic model_update(input bit r, input bit s, input bit p,
                                input bit u, input bit d,
                                input logic [1:0] sel);
        bit tick;
        if (r) begin
            m_acc = 0; m_bpm = 120; m_step = 0; m_len = 16; m_cnt = 0;
            m_play = 0; m_spend = 0; m_ppend = 0;
            e_ccen = 0; e_start = 0; e_stop = 0; e_beat = 0;
            return;
        end
        tick   = (m_acc + m_bpm) >= THRESH;
        m_acc  = m_acc + m_bpm - (tick ? THRESH : 0);
        e_ccen = tick;
        e_start = 0; e_stop = 0; e_beat = 0;
        if (u && !d) m_bpm = (m_bpm + 4 > 240) ? 240 : m_bpm + 4;
        if (d && !u) m_bpm = (m_bpm - 4 < 60) ? 60 : m_bpm - 4;
        if (!m_play) begin
            m_len = len_of(sel);
            if (tick && m_spend) begin
                m_play = 1; m_spend = 0; m_step = 0; e_start = 1;
            end else if (s && !p) begin
                m_spend = 1;
            end else if (p && !s) begin
                m_spend = 0;
            end
        end else begin
            if (tick && m_ppend && m_step != 0) begin
                m_play = 0; m_ppend = 0; m_step = 0; e_stop = 1;
            end else begin
                if (tick) begin
                    m_step = (m_step + 1) % m_len;
                    if (m_step == 0) begin
                        e_beat = 1;
                        m_len  = len_of(sel);
                    end
                end
                if (p) m_ppend = 1;
            end
        end
        if (tick && m_play) m_cnt = TRIG;
        else if (!m_play) m_cnt = 0;
        else if (m_cnt > 0) m_cnt--;
    endtask

    task automatic compare_all();
        check("ccen",     ccen,      e_ccen);
        check("seqstart", seq_start, e_start);
        check("seqstop",  seq_stop,  e_stop);
        check("fourths",  fourths,   m_len == 4);
        check("eighths",  eighths,   m_len == 8);
        check("running",  running,   m_play);
        check("stepidx",  step_idx,  m_step);
        check("bpm",      bpm,       m_bpm);
        check("beat",     beat,      e_beat);
        check("trigwin",  trig_win,  m_cnt != 0);
    endtask

    task automatic cycle(input bit r, input bit s, input bit p,
                         input bit u, input bit d);
        rst = r; start = s; stop = p; up = u; dn = d; ms = cur_ms;
        @(posedge clk);
        model_update(r, s, p, u, d, cur_ms);
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_ccen(input int maxc, output int n);
        n = 0;
        do begin
            cycle(0, 0, 0, 0, 0);
            n++;
        end while (!ccen && n < maxc);
        if (!ccen) check("ccen_timeout", ccen, 1);
    endtask

    task automatic wait_step(input int target);
        int n;
        int k = 0;
        do begin
            wait_ccen(400, n);
            k++;
        end while (step_idx != 4'(target) && k < 40);
        check("step_reach", step_idx, target);
    endtask

    initial begin
        int n;
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check("rst_bpm", bpm, 120);
        check("rst_run", running, 0);
        check("rst_step", step_idx, 0);

        wait_ccen(400, n);
        check("first_ccen", n, 100);
        wait_ccen(400, n);
        check("ccen_period", n, 100);
        cycle(0, 0, 0, 0, 0);
        check("ccen_width", ccen, 0);

        repeat (16) cycle(0, 0, 0, 1, 0);
        check("bpm_184", bpm, 184);
        repeat (20) cycle(0, 0, 0, 1, 0);
        check("bpm_max", bpm, 240);
        cycle(0, 0, 0, 1, 1);
        check("bpm_both", bpm, 240);
        wait_ccen(400, n);
        wait_ccen(400, n);
        check("ccen_240", n, 50);
        repeat (45) cycle(0, 0, 0, 0, 1);
        check("bpm_min", bpm, 60);
        repeat (15) cycle(0, 0, 0, 1, 0);
        check("bpm_back", bpm, 120);

        cycle(1, 0, 0, 0, 0);
        repeat (129) cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        wait_ccen(400, n);
        check("start_lat", n, 70);
        check("start_pulse", seq_start, 1);
        check("start_run", running, 1);
        check("start_step", step_idx, 0);
        n = 0;
        while (trig_win && n < 30) begin
            n++;
            cycle(0, 0, 0, 0, 0);
        end
        check("trig_len", n, TRIG);
        for (int i = 0; i < 16; i++) wait_ccen(400, n);
        check("wrap_step", step_idx, 0);
        check("wrap_beat", beat, 1);

        wait_step(5);
        cur_ms = 2'b10;
        for (int i = 6; i < 16; i++) begin
            wait_ccen(400, n);
            check("meter_hold", fourths, 0);
        end
        wait_ccen(400, n);
        check("meter_wrap", fourths, 1);
        check("meter_beat", beat, 1);
        for (int i = 1; i <= 4; i++) begin
            wait_ccen(400, n);
            check("four_step", step_idx, i % 4);
        end

        cycle(0, 0, 1, 0, 0);
        wait_ccen(400, n);
        check("defer_nostop", seq_stop, 0);
        check("defer_step", step_idx, 1);
        wait_ccen(400, n);
        check("defer_stop", seq_stop, 1);
        check("defer_run", running, 0);
        check("defer_trig", trig_win, 0);

        cur_ms = 2'b00;
        cycle(0, 1, 0, 0, 0);
        wait_ccen(400, n);
        check("restart", seq_start, 1);
        wait_step(6);
        cycle(0, 0, 1, 0, 0);
        wait_ccen(400, n);
        check("stop6", seq_stop, 1);

        cycle(0, 1, 0, 0, 0);
        wait_ccen(400, n);
        repeat (20) cycle(0, 0, 0, 1, 0);
        check("bpm_200", bpm, 200);
        wait_step(7);
        cycle(1, 0, 0, 0, 0);
        check("mid_run", running, 0);
        check("mid_bpm", bpm, 120);
        check("mid_step", step_idx, 0);
        check("mid_trig", trig_win, 0);
        wait_ccen(400, n);
        check("mid_first", n, 100);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(499) == 0) cur_ms = 2'($urandom_range(3));
            cycle($urandom_range(2999) == 0, $urandom_range(149) == 0,
                  $urandom_range(249) == 0, $urandom_range(39) == 0,
                  $urandom_range(39) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
